// File: rtl/sprint_timer_pkg.sv
// Shared state encodings and BCD layout for the sprint stopwatch control path.
// The display bus is five BCD digits, with minutes in the most significant nibble.
package sprint_timer_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_SPLIT = 2'd2,
    S_STOP  = 2'd3
  } state_e;

  localparam logic [3:0] C_DIGIT_MAX = 4'd9;
  localparam logic [3:0] C_TENS_MAX  = 4'd5;

  // Digit positions on the display bus; each digit is one nibble wide.
  localparam int DIG_CSU  = 0;
  localparam int DIG_CST  = 1;
  localparam int DIG_SECU = 2;
  localparam int DIG_SECT = 3;
  localparam int DIG_MIN  = 4;

endpackage

// File: rtl/bcd_time_counter.sv
// Prescaler plus m:ss.cc BCD counter, with saturation at C_MAX_MIN:59.99.
// sat_o is high for one cycle when a tick arrives while the counter already holds the maximum.
module bcd_time_counter
  import sprint_timer_pkg::*;
#(
  parameter int C_TICK_DIV = 1000000,
  parameter int C_MAX_MIN  = 9
) (
  input  logic        I_clk,
  input  logic        I_rst_n,
  input  logic        en_i,
  input  logic        clr_i,
  output logic [19:0] time_o,
  output logic        sat_o
);

  localparam int PW = (C_TICK_DIV > 1) ? $clog2(C_TICK_DIV) : 1;
  localparam logic [PW-1:0] C_PRESC_LAST = PW'(C_TICK_DIV - 1);
  localparam logic [19:0] C_SAT_TIME =
    {4'(C_MAX_MIN), C_TENS_MAX, C_DIGIT_MAX, C_DIGIT_MAX, C_DIGIT_MAX};

  logic [PW-1:0]  presc_q, presc_d;
  logic [4:0][3:0] dig_q, dig_d;
  logic tick;
  logic atMax;

  assign tick   = en_i && (presc_q == C_PRESC_LAST);
  assign atMax  = (dig_q == C_SAT_TIME);
  assign sat_o  = tick && atMax;
  assign time_o = dig_q;

  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      presc_q <= '0;
      dig_q   <= '0;
    end else begin
      presc_q <= presc_d;
      dig_q   <= dig_d;
    end
  end

  // A tick at the maximum leaves the digits frozen; the controller reacts to sat_o.
  always_comb begin
    presc_d = presc_q;
    dig_d   = dig_q;
    if (clr_i) begin
      presc_d = '0;
      dig_d   = '0;
    end else if (en_i) begin
      presc_d = tick ? '0 : presc_q + PW'(1);
      if (tick && !atMax) begin
        dig_d[DIG_CSU] = dig_q[DIG_CSU] + 4'd1;
        if (dig_q[DIG_CSU] == C_DIGIT_MAX) begin
          dig_d[DIG_CSU] = '0;
          dig_d[DIG_CST] = dig_q[DIG_CST] + 4'd1;
          if (dig_q[DIG_CST] == C_DIGIT_MAX) begin
            dig_d[DIG_CST]  = '0;
            dig_d[DIG_SECU] = dig_q[DIG_SECU] + 4'd1;
            if (dig_q[DIG_SECU] == C_DIGIT_MAX) begin
              dig_d[DIG_SECU] = '0;
              dig_d[DIG_SECT] = dig_q[DIG_SECT] + 4'd1;
              if (dig_q[DIG_SECT] == C_TENS_MAX) begin
                dig_d[DIG_SECT] = '0;
                dig_d[DIG_MIN]  = dig_q[DIG_MIN] + 4'd1;
              end
            end
          end
        end
      end
    end
  end

endmodule

// File: rtl/sprint_timer_ctrl.sv
// Stopwatch control FSM: key press detect, idle/run/split/stop sequencing and split freeze.
// A key held through reset release is seen as a fresh press on its first sampled high level.
module sprint_timer_ctrl
  import sprint_timer_pkg::*;
#(
  parameter int C_TICK_DIV = 1000000,
  parameter int C_MAX_MIN  = 9
) (
  input  logic        I_clk,
  input  logic        I_rst_n,
  input  logic        I_key_start,
  input  logic        I_key_clear,
  input  logic        I_key_lap,
  output logic [19:0] O_disp,
  output logic        O_running,
  output logic        O_split,
  output logic        O_ovf,
  output logic [1:0]  O_state
);

  state_e      state_q, state_d;
  logic [2:0]  key_q;
  logic [19:0] frozen_q, frozen_d;
  logic        ovf_q, ovf_d;
  logic        cntClr;
  logic        cntEn;
  logic        sat;
  logic [19:0] liveTime;
  logic        pressStart, pressClear, pressLap;

  assign pressStart = I_key_start & ~key_q[2];
  assign pressClear = I_key_clear & ~key_q[1];
  assign pressLap   = I_key_lap   & ~key_q[0];
  assign cntEn      = (state_q == S_RUN) || (state_q == S_SPLIT);

  bcd_time_counter #(
    .C_TICK_DIV (C_TICK_DIV),
    .C_MAX_MIN  (C_MAX_MIN)
  ) u_counter (
    .I_clk   (I_clk),
    .I_rst_n (I_rst_n),
    .en_i    (cntEn),
    .clr_i   (cntClr),
    .time_o  (liveTime),
    .sat_o   (sat)
  );

  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      state_q  <= S_IDLE;
      key_q    <= '0;
      frozen_q <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      key_q    <= {I_key_start, I_key_clear, I_key_lap};
      frozen_q <= frozen_d;
      ovf_q    <= ovf_d;
    end
  end

  // Saturation overrides any key; otherwise the highest-priority press valid in the state acts.
  always_comb begin
    state_d  = state_q;
    frozen_d = frozen_q;
    ovf_d    = ovf_q;
    cntClr   = 1'b0;
    if (sat) begin
      state_d = S_STOP;
      ovf_d   = 1'b1;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (pressStart) begin
            state_d = S_RUN;
            cntClr  = 1'b1;
          end
        end
        S_RUN: begin
          if (pressStart) begin
            state_d = S_STOP;
          end else if (pressLap) begin
            state_d  = S_SPLIT;
            frozen_d = liveTime;
          end
        end
        S_SPLIT: begin
          if (pressStart) begin
            state_d = S_STOP;
          end else if (pressLap) begin
            state_d = S_RUN;
          end
        end
        S_STOP: begin
          if (pressStart && !ovf_q) begin
            state_d = S_RUN;
          end else if (pressClear) begin
            state_d  = S_IDLE;
            cntClr   = 1'b1;
            frozen_d = '0;
            ovf_d    = 1'b0;
          end
        end
      endcase
    end
  end

  assign O_disp    = (state_q == S_SPLIT) ? frozen_q : liveTime;
  assign O_running = cntEn;
  assign O_split   = (state_q == S_SPLIT);
  assign O_ovf     = ovf_q;
  assign O_state   = state_q;

endmodule
